// File: rtl/exe_muldiv_unit.sv
// EXE-stage multiply/divide unit: one-cycle registered multiply, restoring radix-2 divider,
// tagged valid/ready result port with flush cancel and zero-divisor early-out.
module exe_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [XLEN-1:0]  in_src1,
   input  logic [XLEN-1:0]  in_src2,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);
   localparam int               CNT_W    = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   localparam logic [2:0] OP_MUL   = 3'd0;
   localparam logic [2:0] OP_MULH  = 3'd1;
   localparam logic [2:0] OP_MULHU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MOD   = 3'd5;
   localparam logic [2:0] OP_MODU  = 3'd6;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
      return (is_signed && v[XLEN-1]) ? -v : v;
   endfunction

   function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] mag, input logic negate);
      return negate ? -mag : mag;
   endfunction

   state_t           state;
   logic [CNT_W-1:0] cnt;

   logic [2:0]       op_p0;
   logic [XLEN-1:0]  src1_p0;
   logic [XLEN-1:0]  src2_p0;
   logic [TAG_W-1:0] tag_p0;
   logic [XLEN-1:0]  quo_p0;
   logic [XLEN-1:0]  rem_p0;
   logic [XLEN-1:0]  dvs_p0;
   logic             neg_q_p0;
   logic             neg_r_p0;
   logic             is_rem_p0;

   logic             accept;
   logic             in_is_div;
   logic             in_signed;
   logic             in_is_rem;
   logic             in_zero_div;
   logic [XLEN-1:0]  zero_res;

   logic signed [2*XLEN-1:0] mul_a;
   logic signed [2*XLEN-1:0] mul_b;
   logic signed [2*XLEN-1:0] mul_prod;
   logic [XLEN-1:0]          mul_result;

   logic [XLEN:0]   trial;
   logic [XLEN:0]   diff;
   logic            take;
   logic [XLEN-1:0] rem_nxt;
   logic [XLEN-1:0] quo_nxt;
   logic [XLEN-1:0] div_result;

   assign in_ready = ~flush & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
   assign accept   = in_valid & in_ready;
   assign busy     = (state != ST_IDLE);

   always_comb begin
      in_is_div   = in_op inside {OP_DIV, OP_DIVU, OP_MOD, OP_MODU};
      in_signed   = (in_op == OP_DIV) || (in_op == OP_MOD);
      in_is_rem   = (in_op == OP_MOD) || (in_op == OP_MODU);
      in_zero_div = (in_src2 == '0);
      zero_res    = in_is_rem ? in_src1 : '1;
   end

   // MUL stage: full-width product of the latched operands, sign-extended only for MULH
   always_comb begin
      if (op_p0 == OP_MULH) begin
         mul_a = $signed({{XLEN{src1_p0[XLEN-1]}}, src1_p0});
         mul_b = $signed({{XLEN{src2_p0[XLEN-1]}}, src2_p0});
      end else begin
         mul_a = $signed({{XLEN{1'b0}}, src1_p0});
         mul_b = $signed({{XLEN{1'b0}}, src2_p0});
      end
      mul_prod = mul_a * mul_b;
      case (op_p0)
         OP_MUL:            mul_result = mul_prod[XLEN-1:0];
         OP_MULH, OP_MULHU: mul_result = mul_prod[2*XLEN-1:XLEN];
         default:           mul_result = '0;
      endcase
   end

   // DIV stage: one restoring step on magnitudes; the dividend shifts out of quo_p0 as quotient bits shift in
   always_comb begin
      trial      = {rem_p0, quo_p0[XLEN-1]};
      diff       = trial - {1'b0, dvs_p0};
      take       = ~diff[XLEN];
      rem_nxt    = take ? diff[XLEN-1:0] : trial[XLEN-1:0];
      quo_nxt    = {quo_p0[XLEN-2:0], take};
      div_result = is_rem_p0 ? apply_sign(rem_nxt, neg_r_p0) : apply_sign(quo_nxt, neg_q_p0);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
         cnt        <= '0;
      end else if (flush) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            ST_MUL: begin
               state      <= ST_DONE;
               out_valid  <= 1'b1;
               out_result <= mul_result;
               out_tag    <= tag_p0;
            end
            ST_DIV: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  state      <= ST_DONE;
                  out_valid  <= 1'b1;
                  out_result <= div_result;
                  out_tag    <= tag_p0;
                  cnt        <= '0;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
         // accept is only possible from IDLE or a draining DONE, so it overrides the case above
         if (accept) begin
            if (!in_is_div) begin
               state     <= ST_MUL;
               out_valid <= 1'b0;
            end else if (in_zero_div) begin
               state      <= ST_DONE;
               out_valid  <= 1'b1;
               out_result <= zero_res;
               out_tag    <= in_tag;
            end else begin
               state     <= ST_DIV;
               out_valid <= 1'b0;
               cnt       <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_p0     <= in_op;
         src1_p0   <= in_src1;
         src2_p0   <= in_src2;
         tag_p0    <= in_tag;
         quo_p0    <= magnitude(in_src1, in_signed);
         rem_p0    <= '0;
         dvs_p0    <= magnitude(in_src2, in_signed);
         neg_q_p0  <= in_signed & (in_src1[XLEN-1] ^ in_src2[XLEN-1]);
         neg_r_p0  <= in_signed & in_src1[XLEN-1];
         is_rem_p0 <= in_is_rem;
      end else if (state == ST_DIV) begin
         quo_p0 <= quo_nxt;
         rem_p0 <= rem_nxt;
      end
   end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit at XLEN=32 and XLEN=16: expected results and
// latencies come from an integer-arithmetic reference model; a monitor checks every output.
module tb_exe_muldiv_unit;
   typedef struct {
      logic [31:0] result;
      logic [5:0]  tag;
      int          acc_edge;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid [2];
   logic        in_ready [2];
   logic [2:0]  in_op [2];
   logic [31:0] in_src1 [2];
   logic [31:0] in_src2 [2];
   logic [5:0]  in_tag [2];
   logic        flush [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [31:0] out_result [2];
   logic [5:0]  out_tag [2];
   logic        busy [2];
   logic [31:0] res32;
   logic [15:0] res16;

   exp_t sb0[$];
   exp_t sb1[$];
   logic seen [2];
   int   xlen_of [2] = '{32, 16};
   int   edge_cnt = 0;
   int   compared = 0;
   int   mismatched = 0;

   assign out_result[0] = res32;
   assign out_result[1] = {16'h0, res16};

   exe_muldiv_unit #(.XLEN(32), .TAG_W(6)) dut32 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_op(in_op[0]), .in_src1(in_src1[0]), .in_src2(in_src2[0]), .in_tag(in_tag[0]),
      .flush(flush[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_result(res32), .out_tag(out_tag[0]), .busy(busy[0]));

   exe_muldiv_unit #(.XLEN(16), .TAG_W(6)) dut16 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_op(in_op[1]), .in_src1(in_src1[1][15:0]), .in_src2(in_src2[1][15:0]), .in_tag(in_tag[1]),
      .flush(flush[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_result(res16), .out_tag(out_tag[1]), .busy(busy[1]));

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic logic [31:0] wmask(input int w);
      return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
   endfunction

   // Reference: plain 64-bit integer arithmetic on w-bit operands
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input int w);
      longint unsigned mask, ua, ub, r;
      longint sa, sb;
      mask = {32'h0, wmask(w)};
      ua = {32'h0, a} & mask;
      ub = {32'h0, b} & mask;
      sa = ua;
      sb = ub;
      if (ua[w-1]) sa = sa - (64'sd1 <<< w);
      if (ub[w-1]) sb = sb - (64'sd1 <<< w);
      r = 0;
      case (op)
         3'd0: r = ua * ub;
         3'd1: r = (sa * sb) >>> w;
         3'd2: r = (ua * ub) >> w;
         3'd3: if (ub == 0) r = mask; else r = sa / sb;
         3'd4: if (ub == 0) r = mask; else r = ua / ub;
         3'd5: if (ub == 0) r = ua;   else r = sa % sb;
         3'd6: if (ub == 0) r = ua;   else r = ua % ub;
         default: r = 0;
      endcase
      return 32'(r & mask);
   endfunction

   function automatic int q_size(input int u);
      return (u == 0) ? sb0.size() : sb1.size();
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic mon_unit(input int u);
      exp_t e;
      if (out_valid[u] !== 1'b1) return;
      if (q_size(u) == 0) begin
         compared++;
         mismatched++;
         $display("FAIL u%0d unexpected_valid: out_valid=1 result=0x%08h, expected no output", u, out_result[u]);
         return;
      end
      if (u == 0) e = sb0[0]; else e = sb1[0];
      if (!seen[u]) begin
         seen[u] = 1'b1;
         check($sformatf("u%0d latency tag=%02h", u, e.tag), edge_cnt - e.acc_edge, e.lat);
      end
      if (out_ready[u] === 1'b1 && flush[u] !== 1'b1) begin
         check($sformatf("u%0d result tag=%02h", u, e.tag), out_result[u], e.result);
         check($sformatf("u%0d out_tag", u), {26'h0, out_tag[u]}, {26'h0, e.tag});
         if (u == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
         seen[u] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (resetn === 1'b1)
         for (int u = 0; u < 2; u++) mon_unit(u);
   end

   // Offer one op; the expected entry is queued on the cycle the handshake is seen
   task automatic issue(input int u, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tag, input logic [31:0] expv, input bit rnd_rdy);
      exp_t e;
      int   w;
      w = xlen_of[u];
      in_valid[u] = 1'b1;
      in_op[u]    = op;
      in_src1[u]  = a;
      in_src2[u]  = b;
      in_tag[u]   = tag;
      for (int k = 0; k < 300; k++) begin
         if (rnd_rdy) out_ready[u] = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_ready[u] === 1'b1) begin
            e.result   = expv;
            e.tag      = tag;
            e.acc_edge = edge_cnt + 1;
            if (op inside {3'd3, 3'd4, 3'd5, 3'd6})
               e.lat = ((b & wmask(w)) == 0) ? 0 : w;
            else
               e.lat = 1;
            if (u == 0) sb0.push_back(e); else sb1.push_back(e);
            @(posedge clk);
            #1;
            in_valid[u] = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      check($sformatf("u%0d issue_timeout", u), 32'h0, 32'h1);
      in_valid[u] = 1'b0;
   endtask

   task automatic drain(input int u);
      out_ready[u] = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if (q_size(u) == 0 && out_valid[u] === 1'b0) return;
         @(posedge clk);
         #1;
      end
      check($sformatf("u%0d drain_timeout", u), 32'h0, 32'h1);
   endtask

   function automatic logic [31:0] pick(input int w);
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return wmask(w);
         3: return 32'h1 << (w - 1);
         4: return $urandom_range(0, 20);
         default: return $urandom & wmask(w);
      endcase
   endfunction

   task automatic flush_test(input int u);
      int w;
      w = xlen_of[u];
      out_ready[u] = 1'b1;
      issue(u, 3'd4, 32'd1000, 32'd3, 6'h2A, model(3'd4, 32'd1000, 32'd3, w), 1'b0);
      repeat (9) @(posedge clk);
      #1;
      flush[u]    = 1'b1;
      in_valid[u] = 1'b1;
      in_op[u]    = 3'd0;
      in_src1[u]  = 32'd2;
      in_src2[u]  = 32'd3;
      in_tag[u]   = 6'h15;
      @(negedge clk);
      check($sformatf("u%0d flush in_ready", u), {31'h0, in_ready[u]}, 32'h0);
      @(posedge clk);
      #1;
      flush[u]    = 1'b0;
      in_valid[u] = 1'b0;
      if (u == 0) sb0.delete(); else sb1.delete();
      seen[u] = 1'b0;
      @(negedge clk);
      check($sformatf("u%0d busy after flush", u), {31'h0, busy[u]}, 32'h0);
      check($sformatf("u%0d out_valid after flush", u), {31'h0, out_valid[u]}, 32'h0);
      repeat (w + 8) @(posedge clk);
      #1;
      issue(u, 3'd4, 32'd100, 32'd7, 6'h0E, 32'd14, 1'b0);
      drain(u);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b, r;
      logic [2:0]  d_op  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd3, 3'd5, 3'd4, 3'd6};
      logic [31:0] d_a   [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'h80000000, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
      logic [31:0] d_b   [10] = '{32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
      logic [31:0] d_exp [10] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                  32'h00000000, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'd5};
      resetn = 1'b0;
      for (int u = 0; u < 2; u++) begin
         in_valid[u] = 1'b0; in_op[u] = 3'd0; in_src1[u] = 32'h0; in_src2[u] = 32'h0;
         in_tag[u] = 6'h0; flush[u] = 1'b0; out_ready[u] = 1'b0; seen[u] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check($sformatf("u%0d reset out_valid", u), {31'h0, out_valid[u]}, 32'h0);
         check($sformatf("u%0d reset out_result", u), out_result[u], 32'h0);
         check($sformatf("u%0d reset out_tag", u), {26'h0, out_tag[u]}, 32'h0);
         check($sformatf("u%0d reset busy", u), {31'h0, busy[u]}, 32'h0);
         check($sformatf("u%0d reset in_ready", u), {31'h0, in_ready[u]}, 32'h1);
      end
      @(posedge clk);
      #1;

      out_ready[0] = 1'b1;
      for (int i = 0; i < 10; i++)
         issue(0, d_op[i], d_a[i], d_b[i], 6'(i == 0 ? 8'h25 : 8'h30 + i), d_exp[i], 1'b0);
      drain(0);

      // Backpressure: result held under out_ready=0, then a same-cycle re-issue
      out_ready[0] = 1'b0;
      issue(0, 3'd0, 32'd7, 32'd6, 6'h11, 32'd42, 1'b0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid[0] === 1'b1) break;
      end
      for (int k = 0; k < 4; k++) begin
         check("u0 hold out_valid", {31'h0, out_valid[0]}, 32'h1);
         check("u0 hold result", out_result[0], 32'd42);
         check("u0 hold tag", {26'h0, out_tag[0]}, 32'h11);
         check("u0 hold in_ready", {31'h0, in_ready[0]}, 32'h0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      issue(0, 3'd0, 32'd3, 32'd4, 6'h12, 32'd12, 1'b0);
      drain(0);

      for (int u = 0; u < 2; u++) begin
         flush_test(u);
         for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick(xlen_of[u]);
            b  = pick(xlen_of[u]);
            r  = model(op, a, b, xlen_of[u]);
            issue(u, op, a, b, 6'($urandom_range(0, 63)), r, 1'b1);
         end
         drain(u);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
